simple_uart_wb: RTL and testbench

Wishbone classic responder exposing one 8N1 UART (transmitter and receiver) to a Wishbone initiator through four word registers.
- TX and RX each have a small FIFO.
- The serial line protocol matches the team's AXI-stream UART TX/RX wrappers, so it interoperates with them directly.
- Sits on the peripheral Wishbone bus; `irq` feeds the interrupt aggregator.

---
 rtl/simple_uart_wb.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_simple_uart_wb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_uart_wb.sv
// simple_uart_wb
//   Wishbone classic responder wrapping one 8N1 UART (TX + RX), each side
//   buffered by a small FIFO.
//
// Ports
//   clk, rst                 single clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i       bus cycle / strobe
//   wb_we_i                  write enable
//   wb_adr_i[1:0]            0 DATA, 1 STATUS, 2 CLKDIV, 3 LEVEL
//   wb_dat_i[31:0]           write data
//   wb_sel_i[3:0]            byte lanes (lane 0 gates every write, lane 1 CLKDIV[15:8])
//   wb_dat_o[31:0]           registered read data, valid with ack
//   wb_ack_o                 one-cycle acknowledge
//   tx                       serial out, idle high
//   rx                       serial in, asynchronous to clk
//   irq                      high while the RX FIFO holds data (registered)
module simple_uart_wb #(
    parameter int CLKDIV_DEFAULT = 32,
    parameter int TX_DEPTH_LOG2  = 4,
    parameter int RX_DEPTH_LOG2  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);

    localparam int TXD = 1 << TX_DEPTH_LOG2;
    localparam int RXD = 1 << RX_DEPTH_LOG2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        ack_q;
    logic [31:0] dat_q;
    logic        bus_req;
    logic        wr_data, rd_data, wr_status, wr_clkdiv;

    // ~ack_q makes a held strobe complete only every other cycle.
    assign bus_req   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_data   = bus_req &  wb_we_i & (wb_adr_i == 2'd0) & wb_sel_i[0];
    assign rd_data   = bus_req & ~wb_we_i & (wb_adr_i == 2'd0);
    assign wr_status = bus_req &  wb_we_i & (wb_adr_i == 2'd1) & wb_sel_i[0];
    assign wr_clkdiv = bus_req &  wb_we_i & (wb_adr_i == 2'd2) & wb_sel_i[0];

    // Upper data lanes and byte selects have no register behind them.
    logic unused_bits;
    assign unused_bits = ^{wb_dat_i[31:16], wb_sel_i[3:2]};

    // ------------------------------------------------------------------
    // TX FIFO (pointers carry one extra wrap bit so full/empty are distinct)
    // ------------------------------------------------------------------
    logic [7:0]             tx_mem [TXD];
    logic [TX_DEPTH_LOG2:0] tx_wr_q, tx_rd_q, tx_count;
    logic                   tx_empty, tx_full, tx_pop, tx_push, tx_drop;
    logic [7:0]             tx_head;

    assign tx_count = tx_wr_q - tx_rd_q;
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = tx_count[TX_DEPTH_LOG2];
    assign tx_head  = tx_mem[tx_rd_q[TX_DEPTH_LOG2-1:0]];
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still lands (it overwrites the entry being read out this cycle).
    assign tx_push  = wr_data & (~tx_full | tx_pop);
    assign tx_drop  = wr_data & tx_full & ~tx_pop;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q[TX_DEPTH_LOG2-1:0]] <= wb_dat_i[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]             rx_mem [RXD];
    logic [RX_DEPTH_LOG2:0] rx_wr_q, rx_rd_q, rx_count;
    logic                   rx_empty, rx_full, rx_pop, rx_push, rx_push_req, rx_ovr_set;
    logic [7:0]             rx_head, rx_shift_q, rx_shift_d;

    assign rx_count   = rx_wr_q - rx_rd_q;
    assign rx_empty   = (rx_wr_q == rx_rd_q);
    assign rx_full    = rx_count[RX_DEPTH_LOG2];
    assign rx_head    = rx_mem[rx_rd_q[RX_DEPTH_LOG2-1:0]];
    assign rx_pop     = rd_data & ~rx_empty;
    assign rx_push    = rx_push_req & (~rx_full | rx_pop);
    assign rx_ovr_set = rx_push_req & rx_full & ~rx_pop;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_q[RX_DEPTH_LOG2-1:0]] <= rx_shift_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_q <= '0;
            rx_rd_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control registers and sticky flags
    // ------------------------------------------------------------------
    logic [15:0] clkdiv_q, clkdiv_wr_val;
    logic        tx_ovf_q, rx_ovr_q, frame_err_q, frame_err_set, irq_q;

    assign clkdiv_wr_val = {wb_sel_i[1] ? wb_dat_i[15:8] : clkdiv_q[15:8], wb_dat_i[7:0]};

    // A flag raised in the same cycle as a clear wins, so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkdiv_q    <= 16'(CLKDIV_DEFAULT);
            tx_ovf_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_clkdiv)
                clkdiv_q <= (clkdiv_wr_val < 16'd4) ? 16'd4 : clkdiv_wr_val;
            if (tx_drop)                        tx_ovf_q    <= 1'b1;
            else if (wr_status && wb_dat_i[7])  tx_ovf_q    <= 1'b0;
            if (rx_ovr_set)                     rx_ovr_q    <= 1'b1;
            else if (wr_status && wb_dat_i[4])  rx_ovr_q    <= 1'b0;
            if (frame_err_set)                  frame_err_q <= 1'b1;
            else if (wr_status && wb_dat_i[5])  frame_err_q <= 1'b0;
            irq_q <= ~rx_empty;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        tx_line_q, tx_line_d, tx_bit_end, tx_busy;

    assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
    assign tx_busy    = (tx_state_q != TX_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_div_d   = tx_div_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d  = '0;
                tx_line_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_div_d   = clkdiv_q;
                    tx_line_d  = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit: no idle gap.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_div_d   = clkdiv_q;
                        tx_line_d  = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= 16'(CLKDIV_DEFAULT);
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // ------------------------------------------------------------------
    // RX synchronizer and FSM
    // ------------------------------------------------------------------
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q, rx_bit_end;

    assign rx_half    = {1'b0, rx_div_q[15:1]};
    assign rx_bit_end = (rx_cnt_q == rx_div_q - 16'd1);

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q + 16'd1;
        rx_div_d      = rx_div_q;
        rx_shift_d    = rx_shift_q;
        rx_bit_d      = rx_bit_q;
        rx_push_req   = 1'b0;
        frame_err_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_div_d   = clkdiv_q;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Half a bit in: a line back high means the edge was a glitch.
                if (rx_cnt_q == rx_half - 16'd1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_d      = '0;
                    rx_push_req   = rx_sync_q;
                    frame_err_set = ~rx_sync_q;
                    rx_state_d    = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= 16'(CLKDIV_DEFAULT);
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and bus response
    // ------------------------------------------------------------------
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        case (wb_adr_i)
            2'd0: rd_val = rx_empty ? 32'd0 : {24'd0, rx_head};
            2'd1: rd_val = {24'd0, tx_ovf_q, tx_busy, frame_err_q, rx_ovr_q,
                            rx_full, rx_empty, tx_empty, tx_full};
            2'd2: rd_val = {16'd0, clkdiv_q};
            2'd3: rd_val = {16'd0, 8'(tx_count), 8'(rx_count)};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= bus_req;
            if (bus_req && !wb_we_i) dat_q <= rd_val;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign tx       = tx_line_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_simple_uart_wb.sv
// Bench for simple_uart_wb: bus tasks, a TX line monitor fed by a scoreboard
// queue of bytes written to DATA, and direct register checks.
module tb_simple_uart_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [1:0]  wb_adr = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack, tx, irq;
    logic        loop_en = 1'b0, rx_drv = 1'b1;
    logic        rx_line;

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    simple_uart_wb dut (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc_i (wb_cyc),
        .wb_stb_i (wb_stb),
        .wb_we_i  (wb_we),
        .wb_adr_i (wb_adr),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack),
        .tx       (tx),
        .rx       (rx_line),
        .irq      (irq)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         exp_div = 32;
    logic       mon_en = 1'b1;
    logic       b2b_en = 1'b0;
    logic       frame_active = 1'b0;
    logic       expect_start = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where ack is seen.
    task automatic wb_access(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rdat);
        int n = 0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat; wb_sel = sel;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack && n < 16);
        check_eq("ack_seen", {31'd0, wb_ack}, 32'd1);
        rdat = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        $display("wb %s adr=%0d wdat=0x%08h sel=%h rdat=0x%08h", we ? "wr" : "rd", adr, dat, sel, rdat);
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_access(1'b1, adr, dat, sel, dummy);
    endtask

    task automatic read_chk(input string tag, input logic [1:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        wb_access(1'b0, adr, 32'd0, 4'h0, r);
        check_eq(tag, r, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        wb_write(2'd0, {24'd0, b}, 4'h1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || frame_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_in_time", {31'd0, n < budget}, 32'd1);
    endtask

    task automatic wait_irq(input int budget);
        int n = 0;
        while (!irq && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("irq_rise", {31'd0, irq}, 32'd1);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit, input int div);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = fr[i];
            repeat (div) @(negedge clk);
        end
        rx_drv = 1'b1;
        $display("rx drive byte=0x%02h stop=%0d", b, stop_bit);
    endtask

    // TX monitor: every bit must hold its value for exactly exp_div clocks.
    initial begin : tx_mon
        logic [9:0] fr;
        logic       bad;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (expect_start) begin
                check_eq("b2b_no_gap", {31'd0, tx}, 32'd0);
                expect_start = 1'b0;
            end
            if (mon_en && !rst && tx === 1'b0) begin
                frame_active = 1'b1;
                bad = 1'b0;
                fr = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < exp_div; k++) begin
                        if (!(b == 0 && k == 0)) @(negedge clk);
                        if (k == 0) fr[b] = tx;
                        else if (tx !== fr[b]) bad = 1'b1;
                    end
                end
                if (exp_q.size() == 0) begin
                    check_eq("tx_extra_frame", exp_q.size(), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("tx_frame", {21'd0, bad, fr}, {21'd0, 1'b0, 1'b1, e, 1'b0});
                    $display("tx frame byte=0x%02h exp=0x%02h width_err=%0d", fr[8:1], e, bad);
                end
                if (b2b_en && exp_q.size() > 0) expect_start = 1'b1;
                frame_active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] r;
        int prev, cur, n;

        // 1. reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_tx", {31'd0, tx}, 32'd1);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        check_eq("rst_ack", {31'd0, wb_ack}, 32'd0);
        check_eq("rst_dat", wb_dat_o, 32'd0);
        read_chk("rst_status", 2'd1, 32'h06);
        read_chk("rst_clkdiv", 2'd2, 32'd32);
        read_chk("rst_level", 2'd3, 32'd0);

        // 2. loopback single byte
        loop_en = 1'b1;
        send_byte(8'h55);
        wait_irq(1000);
        read_chk("rx_55", 2'd0, 32'h55);
        repeat (2) @(negedge clk);
        check_eq("irq_fall", {31'd0, irq}, 32'd0);
        wait_drain(1000);
        repeat (4) @(negedge clk);
        read_chk("status_after_55", 2'd1, 32'h06);

        // 3. TX overflow. The first byte moves straight into the shifter,
        //    so 17 writes are needed to fill the 16-entry FIFO.
        loop_en = 1'b0;
        b2b_en = 1'b1;
        for (int i = 0; i <= 16; i++) send_byte(8'(i));
        wb_write(2'd0, 32'hAA, 4'h1);
        read_chk("status_txfull_ovf", 2'd1, 32'hC5);
        read_chk("level_full", 2'd3, 32'h1000);
        prev = 16;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            repeat (100) @(negedge clk);
            wb_access(1'b0, 2'd3, 32'd0, 4'h0, r);
            cur = int'(r[15:8]);
            check_eq("level_step", {31'd0, (cur <= prev) && (prev - cur <= 1)}, 32'd1);
            prev = cur;
            n++;
        end
        wait_drain(2000);
        b2b_en = 1'b0;
        repeat (4) @(negedge clk);
        read_chk("level_empty", 2'd3, 32'h0);
        read_chk("status_ovf_sticky", 2'd1, 32'h86);
        wb_write(2'd1, 32'h80, 4'h1);
        read_chk("status_ovf_clr", 2'd1, 32'h06);

        // 4. RX overrun via loopback
        loop_en = 1'b1;
        for (int i = 16; i <= 32; i++) send_byte(8'(i));
        wait_drain(8000);
        repeat (40) @(negedge clk);
        read_chk("status_rx_ovr", 2'd1, 32'h1A);
        read_chk("level_rx_full", 2'd3, 32'h10);
        check_eq("irq_rx_full", {31'd0, irq}, 32'd1);
        for (int i = 0; i < 16; i++) read_chk("rx_drain", 2'd0, 32'h10 + 32'(i));
        read_chk("rx_empty_read", 2'd0, 32'd0);
        wb_write(2'd1, 32'h10, 4'h1);
        read_chk("status_ovr_clr", 2'd1, 32'h06);
        repeat (2) @(negedge clk);
        check_eq("irq_after_drain", {31'd0, irq}, 32'd0);

        // 5. glitch, framing error, clean external frame
        loop_en = 1'b0;
        rx_drv = 1'b0;
        repeat (8) @(negedge clk);
        rx_drv = 1'b1;
        repeat (100) @(negedge clk);
        read_chk("status_glitch", 2'd1, 32'h06);
        drive_rx(8'hA5, 1'b0, 32);
        repeat (64) @(negedge clk);
        read_chk("status_frame_err", 2'd1, 32'h26);
        drive_rx(8'hC3, 1'b1, 32);
        repeat (64) @(negedge clk);
        read_chk("rx_ext_c3", 2'd0, 32'hC3);
        wb_write(2'd1, 32'h20, 4'h1);
        read_chk("status_fe_clr", 2'd1, 32'h06);

        // 6. CLKDIV, byte lanes, asynchronous reset mid-frame
        wb_write(2'd2, 32'd8, 4'h3);
        read_chk("clkdiv_8", 2'd2, 32'd8);
        exp_div = 8;
        loop_en = 1'b1;
        send_byte(8'h3C);
        wait_irq(500);
        read_chk("rx_3c_div8", 2'd0, 32'h3C);
        wait_drain(500);
        wb_write(2'd2, 32'd2, 4'h3);
        read_chk("clkdiv_clamp", 2'd2, 32'd4);
        wb_write(2'd2, 32'h0140, 4'h1);
        read_chk("clkdiv_lane0", 2'd2, 32'h40);
        wb_write(2'd2, 32'h0055, 4'h2);
        read_chk("clkdiv_no_lane0", 2'd2, 32'h40);
        mon_en = 1'b0;
        wb_write(2'd0, 32'h99, 4'h1);
        repeat (3) @(negedge clk);
        check_eq("pre_rst_tx_low", {31'd0, tx}, 32'd0);
        #2 rst = 1'b1;
        #1 check_eq("rst_tx_async", {31'd0, tx}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_chk("status_post_rst", 2'd1, 32'h06);
        read_chk("clkdiv_post_rst", 2'd2, 32'd32);
        read_chk("level_post_rst", 2'd3, 32'd0);
        check_eq("irq_post_rst", {31'd0, irq}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
